// File: rtl/rx_iq_packer.sv
// ---------------------------------------------------------------------------
// rx_iq_packer
//
// Purpose:
//   Buffers strobed 24-bit I/Q samples from the receiver in a small sample
//   FIFO and serialises each sample as two sign-extended 32-bit AXI-stream
//   words (I first, then Q) toward the DMA path. Reports the FIFO level and
//   counts samples dropped because the FIFO was full. Optionally marks frame
//   boundaries with m_tlast.
//
// Configuration macro:
//   RX_IQ_PACKER_FRAME_EN
//     defined   : a write-side frame counter tags every FRAME_SAMPLES-th
//                 sample; m_tlast is raised on that sample's Q word.
//     undefined : no frame counter, 48-bit FIFO entries, m_tlast tied to 0,
//                 FRAME_SAMPLES has no effect.
//
// Parameters:
//   DEPTH          FIFO capacity in samples (power of two, >= 2)
//   FRAME_SAMPLES  samples per frame for m_tlast generation (>= 1)
//
// Ports:
//   clock           sample-domain clock, rising edge
//   reset           asynchronous, active-high reset
//   enable          when low, strobes are ignored and frame position held at 0
//   in_strobe       one-cycle pulse qualifying in_i / in_q
//   in_i, in_q      signed 24-bit I and Q samples
//   m_tdata         stream word, sign-extended I or Q
//   m_tvalid        stream valid (FIFO not empty)
//   m_tready        stream ready
//   m_tlast         last word of a frame
//   level           samples held, including a partially sent one
//   overflow        sticky flag: a sample was dropped
//   overflow_count  dropped-sample count, saturating at 16'hFFFF
//   overflow_clear  one-cycle pulse clearing overflow and overflow_count
// ---------------------------------------------------------------------------
module rx_iq_packer #(
  parameter int DEPTH         = 16,
  parameter int FRAME_SAMPLES = 256
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_strobe,
  input  logic [23:0]              in_i,
  input  logic [23:0]              in_q,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              overflow_count,
  input  logic                     overflow_clear
);

  localparam int AW = $clog2(DEPTH);

`ifdef RX_IQ_PACKER_FRAME_EN
  localparam int EW = 49;
  localparam int FW = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
`else
  localparam int EW = 48;
`endif

  // Sample storage; contents need no reset because count_q gates every read.
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   overflow_count_q, overflow_count_d;

  logic          fifo_empty;
  logic          fifo_full;
  logic          handshake;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

`ifdef RX_IQ_PACKER_FRAME_EN
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          frame_last;
`else
  logic          unused_frame_samples;
  assign unused_frame_samples = ^FRAME_SAMPLES;
`endif

  // Handshake and FIFO status. A full FIFO may still accept a sample in
  // the same cycle its head entry finishes (Q word handshake frees a slot).
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (AW+1)'(DEPTH));
    handshake  = !fifo_empty && m_tready;
    pop        = handshake && phase_q;
    push       = enable && in_strobe && (!fifo_full || pop);
    drop       = enable && in_strobe && !push;
  end

`ifdef RX_IQ_PACKER_FRAME_EN
  // Frame position on the write side. Only accepted samples advance it;
  // disabling the block restarts the frame without touching stored flags.
  always_comb begin
    frame_last  = (frame_cnt_q == FW'(FRAME_SAMPLES - 1));
    frame_cnt_d = frame_cnt_q;
    if (!enable) begin
      frame_cnt_d = '0;
    end else if (push) begin
      frame_cnt_d = frame_last ? '0 : frame_cnt_q + 1'b1;
    end
  end

  always_comb begin
    wr_entry = {frame_last, in_i, in_q};
  end
`else
  always_comb begin
    wr_entry = {in_i, in_q};
  end
`endif

  // Pointer, occupancy and read-phase next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    phase_d  = phase_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (handshake) begin
      phase_d = !phase_q;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Overflow bookkeeping; a clear wins over a coincident drop.
  always_comb begin
    overflow_d       = overflow_q;
    overflow_count_d = overflow_count_q;
    if (overflow_clear) begin
      overflow_d       = 1'b0;
      overflow_count_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (overflow_count_q != 16'hFFFF) begin
        overflow_count_d = overflow_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      phase_q          <= 1'b0;
      overflow_q       <= 1'b0;
      overflow_count_q <= '0;
    end else begin
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      phase_q          <= phase_d;
      overflow_q       <= overflow_d;
      overflow_count_q <= overflow_count_d;
    end
  end

`ifdef RX_IQ_PACKER_FRAME_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`endif

  // When full, wr_ptr equals rd_ptr, but a write then only happens together
  // with a pop, so the entry being overwritten has already been sent.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Output words come straight from the head entry, so they hold steady
  // while stalled because neither rd_ptr_q nor phase_q move.
  always_comb begin
    rd_entry = mem_q[rd_ptr_q];
    m_tvalid = !fifo_empty;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (!fifo_empty) begin
      if (phase_q) begin
        m_tdata = {{8{rd_entry[23]}}, rd_entry[23:0]};
`ifdef RX_IQ_PACKER_FRAME_EN
        m_tlast = rd_entry[48];
`endif
      end else begin
        m_tdata = {{8{rd_entry[47]}}, rd_entry[47:24]};
      end
    end
    level          = count_q;
    overflow       = overflow_q;
    overflow_count = overflow_count_q;
  end

endmodule

// File: tb/tb_rx_iq_packer.sv
// ---------------------------------------------------------------------------
// tb_rx_iq_packer
//
// Self-checking bench for rx_iq_packer (DEPTH = 16, FRAME_SAMPLES = 4).
// A queue of whole samples plus a "half sent" bit stands in for the design;
// every cycle the expected stream outputs are derived from that queue.
// ---------------------------------------------------------------------------
module tb_rx_iq_packer;

  localparam int DEPTH = 16;
  localparam int FS    = 4;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        in_strobe;
  logic [23:0] in_i;
  logic [23:0] in_q;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] overflow_count;
  logic        overflow_clear;

  typedef struct {
    logic [23:0] i;
    logic [23:0] q;
    logic        last;
  } sample_t;

  sample_t mq[$];
  logic    m_half;
  int      m_fpos;
  logic    m_ovf;
  int      m_ovf_cnt;

  int tests;
  int fails;
  int words_seen;
  int last_words[$];

  rx_iq_packer #(.DEPTH(DEPTH), .FRAME_SAMPLES(FS)) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .in_strobe      (in_strobe),
    .in_i           (in_i),
    .in_q           (in_q),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
    .level          (level),
    .overflow       (overflow),
    .overflow_count (overflow_count),
    .overflow_clear (overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  // Compare every output against the expectation implied by the queue.
  task automatic checkModel();
    logic [31:0] exp_data;
    logic        exp_last;
    checkOutput("tvalid", {31'd0, m_tvalid}, {31'd0, mq.size() > 0});
    checkOutput("level", {27'd0, level}, mq.size());
    checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    checkOutput("ovf_count", {16'd0, overflow_count}, m_ovf_cnt);
    if (mq.size() > 0) begin
      exp_data = m_half ? sext(mq[0].q) : sext(mq[0].i);
`ifdef RX_IQ_PACKER_FRAME_EN
      exp_last = m_half && mq[0].last;
`else
      exp_last = 1'b0;
`endif
      checkOutput("tdata", m_tdata, exp_data);
      checkOutput("tlast", {31'd0, m_tlast}, {31'd0, exp_last});
    end
  endtask

  // Drive one cycle of inputs, advance the model by the stream rules,
  // then check the design one time unit after the clock edge.
  task automatic applyStimulus(input logic strb, input logic en, input logic rdy,
                               input logic clr, input logic [23:0] si, input logic [23:0] sq);
    logic    hs;
    logic    pop;
    logic    accept;
    logic    dropped;
    sample_t s;
    in_strobe      = strb;
    enable         = en;
    m_tready       = rdy;
    overflow_clear = clr;
    in_i           = si;
    in_q           = sq;
    if (rdy && m_tvalid) begin
      words_seen++;
      if (m_tlast) last_words.push_back(words_seen);
    end
    hs      = (mq.size() > 0) && rdy;
    pop     = hs && m_half;
    accept  = en && strb && ((mq.size() < DEPTH) || pop);
    dropped = en && strb && !accept;
    if (hs) m_half = !m_half;
    if (pop) mq.delete(0);
    if (accept) begin
      s.i    = si;
      s.q    = sq;
      s.last = (m_fpos == FS - 1);
      mq.push_back(s);
      m_fpos = s.last ? 0 : m_fpos + 1;
    end else if (!en) begin
      m_fpos = 0;
    end
    if (clr) begin
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
    end else if (dropped) begin
      m_ovf = 1'b1;
      if (m_ovf_cnt < 65535) m_ovf_cnt++;
    end
    @(posedge clock);
    #1;
    checkModel();
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, rdy, 1'b0, 24'h0, 24'h0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic doReset();
    in_strobe      = 1'b0;
    overflow_clear = 1'b0;
    m_tready       = 1'b0;
    reset          = 1'b1;
    #1;
    checkOutput("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    checkOutput("rst_tdata", m_tdata, 32'd0);
    checkOutput("rst_tlast", {31'd0, m_tlast}, 32'd0);
    checkOutput("rst_level", {27'd0, level}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_ovf_count", {16'd0, overflow_count}, 32'd0);
    mq.delete();
    m_half    = 1'b0;
    m_fpos    = 0;
    m_ovf     = 1'b0;
    m_ovf_cnt = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkModel();
  endtask

  initial begin
    int words_before;
    tests          = 0;
    fails          = 0;
    words_seen     = 0;
    enable         = 1'b1;
    in_strobe      = 1'b0;
    in_i           = '0;
    in_q           = '0;
    m_tready       = 1'b0;
    overflow_clear = 1'b0;
    reset          = 1'b0;

    doReset();

    // Sign extension and one-cycle latency.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'h800000, 24'h000001);
    checkOutput("sx_valid", {31'd0, m_tvalid}, 32'd1);
    checkOutput("sx_iword", m_tdata, 32'hFF800000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
    checkOutput("sx_qword", m_tdata, 32'h00000001);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
    checkOutput("sx_level", {27'd0, level}, 32'd0);

    // Reset mid-stream with 5 samples queued and one half sent.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 24'h0);
    end
    checkOutput("pre_rst_level", {27'd0, level}, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
    #2;
    doReset();
    idleCycles(4, 1'b1);

    // Overflow: 19 strobes into a stalled 16-deep FIFO.
    for (int k = 0; k < 19; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
    checkOutput("ovf_level", {27'd0, level}, 32'd16);
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_cnt3", {16'd0, overflow_count}, 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h123456, 24'h654321);
    checkOutput("ovf_clr_cnt", {16'd0, overflow_count}, 32'd0);
    checkOutput("ovf_clr_flag", {31'd0, overflow}, 32'd0);
    words_before = words_seen;
    idleCycles(34, 1'b1);
    checkOutput("drain_words", words_seen - words_before, 32'd32);

    // Full FIFO with a write coinciding with the Q-word handshake.
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 24'($urandom), 24'($urandom));
    checkOutput("fp_full", {27'd0, level}, 32'd16);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 24'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 24'hABCDEF, 24'h7FFFFF);
    checkOutput("fp_level", {27'd0, level}, 32'd16);
    checkOutput("fp_ovf_cnt", {16'd0, overflow_count}, 32'd0);
    checkOutput("fp_ovf", {31'd0, overflow}, 32'd0);
    idleCycles(40, 1'b1);

    // Framing: 8 samples, then an enable gap after 2 samples.
    doReset();
    words_seen = 0;
    last_words.delete();
    for (int k = 0; k < 20; k++)
      applyStimulus((k < 16) && (k % 2 == 0), 1'b1, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
`ifdef RX_IQ_PACKER_FRAME_EN
    checkOutput("frm_nlast", last_words.size(), 32'd2);
    if (last_words.size() == 2) begin
      checkOutput("frm_last0", last_words[0], 32'd8);
      checkOutput("frm_last1", last_words[1], 32'd16);
    end
`else
    checkOutput("frm_nlast", last_words.size(), 32'd0);
`endif
    words_seen = 0;
    last_words.delete();
    for (int k = 0; k < 4; k++)
      applyStimulus(k % 2 == 0, 1'b1, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 24'h111111, 24'h222222);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 24'h0);
    for (int k = 0; k < 12; k++)
      applyStimulus((k < 8) && (k % 2 == 0), 1'b1, 1'b1, 1'b0, 24'($urandom), 24'($urandom));
    checkOutput("gap_words", words_seen, 32'd12);
`ifdef RX_IQ_PACKER_FRAME_EN
    checkOutput("gap_nlast", last_words.size(), 32'd1);
    if (last_words.size() == 1) checkOutput("gap_last", last_words[0], 32'd12);
`else
    checkOutput("gap_nlast", last_words.size(), 32'd0);
`endif

    // Random backpressure with a strobe every third cycle.
    for (int k = 0; k < 300; k++)
      applyStimulus(k % 3 == 0, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                    24'($urandom), 24'($urandom));
    idleCycles(60, 1'b1);
    checkOutput("bp_empty", {27'd0, level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
